keccak_squeeze_unit: RTL and testbench

Output-side streamer for the Keccak engine. It takes the permuted 1600-bit state after absorption ends and emits the requested number of digest/XOF bytes as a 256-bit AXI-Stream. When SHAKE output exceeds one rate block, it requests further permutations. Bytes that straddle a block boundary are packed through a carry register, so every beat except the last is full.

---
 rtl/keccak_squeeze_unit.sv | 200 ++++++++++++++++++++
 tb/tb_keccak_squeeze_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_squeeze_unit.sv
// Keccak squeeze streamer: state rate bytes -> 256-bit AXI-Stream, carry-packed across blocks (1 cycle from state_valid_i to tvalid).
// Holds beats stable under tready backpressure; KECCAK_SQUEEZE_STATS_EN adds perm_cnt_o.
module keccak_squeeze_unit #(
    parameter int DWIDTH        = 256,
    parameter int STATE_WIDTH   = 1600,
    parameter int RATE_WIDTH    = 11,
    parameter int OUT_LEN_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic [RATE_WIDTH-1:0]    rate_i,
    input  logic [OUT_LEN_WIDTH-1:0] out_len_i,
    input  logic [STATE_WIDTH-1:0]   state_i,
    input  logic                     state_valid_i,
    output logic                     perm_req_o,
    output logic [DWIDTH-1:0]        m_axis_tdata,
    output logic [DWIDTH/8-1:0]      m_axis_tkeep,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic                     busy_o,
`ifdef KECCAK_SQUEEZE_STATS_EN
    output logic                     done_o,
    output logic [15:0]              perm_cnt_o
`else
    output logic                     done_o
`endif
);
    localparam int BB      = DWIDTH / 8;
    localparam int PW      = RATE_WIDTH - 3;
    localparam int CW      = $clog2(BB) + 1;
    localparam int CARRY_W = DWIDTH - 64;

    typedef enum logic [1:0] {IDLE, WAIT_STATE, STREAM, PERM} state_e;

    state_e                   state_q, state_d;
    logic [PW-1:0]            rate_bytes_q, rate_bytes_d, rd_ptr_q, rd_ptr_d;
    logic [OUT_LEN_WIDTH-1:0] out_rem_q, out_rem_d;
    logic [CW-1:0]            carry_cnt_q, carry_cnt_d;
    logic [CARRY_W-1:0]       carry_q, carry_d;
    logic [DWIDTH-1:0]        tdata_q, tdata_d;
    logic [BB-1:0]            tkeep_q, tkeep_d;
    logic                     tvalid_q, tvalid_d, tlast_q, tlast_d;
    logic                     perm_req_q, perm_req_d, busy_q, busy_d, done_q, done_d;

    logic [PW-1:0]            ptr, blk_rem;
    logic [OUT_LEN_WIDTH-1:0] data_rem;
    logic [CW-1:0]            room, need, take, beat_bytes;
    logic [DWIDTH-1:0]        win, taken, shifted;
    logic                     fits, step;

    // Datapath for one packing step; ptr restarts at 0 whenever a fresh block arrives.
    always_comb begin
        ptr        = (state_q == STREAM) ? rd_ptr_q : '0;
        blk_rem    = rate_bytes_q - ptr;
        room       = CW'(BB) - carry_cnt_q;
        data_rem   = out_rem_q - OUT_LEN_WIDTH'(carry_cnt_q);
        need       = (OUT_LEN_WIDTH'(room) <= data_rem) ? room : CW'(data_rem);
        fits       = (blk_rem >= PW'(need));
        take       = fits ? need : CW'(blk_rem);
        win        = DWIDTH'(state_i >> {ptr, 3'b000});
        taken      = win & ~({DWIDTH{1'b1}} << {take, 3'b000});
        shifted    = taken << {carry_cnt_q, 3'b000};
        beat_bytes = carry_cnt_q + need;
    end

    always_comb begin
        state_d      = state_q;
        rate_bytes_d = rate_bytes_q;
        rd_ptr_d     = rd_ptr_q;
        out_rem_d    = out_rem_q;
        carry_cnt_d  = carry_cnt_q;
        carry_d      = carry_q;
        tdata_d      = tdata_q;
        tkeep_d      = tkeep_q;
        tvalid_d     = tvalid_q;
        tlast_d      = tlast_q;
        perm_req_d   = perm_req_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        step         = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (out_len_i != '0) begin
                        rate_bytes_d = PW'(rate_i >> 3);
                        out_rem_d    = out_len_i;
                        carry_cnt_d  = '0;
                        carry_d      = '0;
                        busy_d       = 1'b1;
                        state_d      = WAIT_STATE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            WAIT_STATE, PERM: begin
                if (state_valid_i) step = 1'b1;
            end
            STREAM: begin
                if (tvalid_q && m_axis_tready) begin
                    if (tlast_q) begin
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (step) begin
            if (fits) begin
                tdata_d     = shifted | {{(DWIDTH-CARRY_W){1'b0}}, carry_q};
                tkeep_d     = ~({BB{1'b1}} << beat_bytes);
                tlast_d     = (out_rem_q == OUT_LEN_WIDTH'(beat_bytes));
                tvalid_d    = 1'b1;
                rd_ptr_d    = ptr + PW'(need);
                out_rem_d   = out_rem_q - OUT_LEN_WIDTH'(beat_bytes);
                carry_d     = '0;
                carry_cnt_d = '0;
                perm_req_d  = 1'b0;
                state_d     = STREAM;
            end else begin
                // Block tail goes into carry; the next beat is completed from the next block.
                tvalid_d    = 1'b0;
                tlast_d     = 1'b0;
                carry_d     = carry_q | shifted[CARRY_W-1:0];
                carry_cnt_d = carry_cnt_q + CW'(blk_rem);
                perm_req_d  = 1'b1;
                state_d     = PERM;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rate_bytes_q <= '0;
            rd_ptr_q     <= '0;
            out_rem_q    <= '0;
            carry_cnt_q  <= '0;
            carry_q      <= '0;
            tdata_q      <= '0;
            tkeep_q      <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            perm_req_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rate_bytes_q <= rate_bytes_d;
            rd_ptr_q     <= rd_ptr_d;
            out_rem_q    <= out_rem_d;
            carry_cnt_q  <= carry_cnt_d;
            carry_q      <= carry_d;
            tdata_q      <= tdata_d;
            tkeep_q      <= tkeep_d;
            tvalid_q     <= tvalid_d;
            tlast_q      <= tlast_d;
            perm_req_q   <= perm_req_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

`ifdef KECCAK_SQUEEZE_STATS_EN
    logic [15:0] perm_cnt_q, perm_cnt_d;

    always_comb begin
        perm_cnt_d = perm_cnt_q;
        if (state_q == IDLE && start_i)
            perm_cnt_d = '0;
        else if (perm_req_d && !perm_req_q && perm_cnt_q != 16'hFFFF)
            perm_cnt_d = perm_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) perm_cnt_q <= '0;
        else        perm_cnt_q <= perm_cnt_d;
    end

    assign perm_cnt_o = perm_cnt_q;
`endif

    assign perm_req_o    = perm_req_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
endmodule

// File: tb/tb_keccak_squeeze_unit.sv
// Randomized bench for keccak_squeeze_unit: expected output is the concatenation of every delivered block's rate bytes.
module tb_keccak_squeeze_unit;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic [10:0]   rate_i = '0;
    logic [15:0]   out_len_i = '0;
    logic [1599:0] state_i = '0;
    logic          state_valid_i = 1'b0;
    logic          perm_req_o;
    logic [255:0]  m_axis_tdata;
    logic [31:0]   m_axis_tkeep;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic          m_axis_tlast;
    logic          busy_o;
    logic          done_o;
`ifdef KECCAK_SQUEEZE_STATS_EN
    logic [15:0]   perm_cnt_o;
`endif

    always #5 clk = ~clk;

    keccak_squeeze_unit dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .rate_i(rate_i), .out_len_i(out_len_i),
        .state_i(state_i), .state_valid_i(state_valid_i), .perm_req_o(perm_req_o),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .busy_o(busy_o),
`ifdef KECCAK_SQUEEZE_STATS_EN
        .done_o(done_o), .perm_cnt_o(perm_cnt_o)
`else
        .done_o(done_o)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    byte unsigned exp_q[$];
    byte unsigned got_q[$];
    logic [31:0]  keep_q[$];
    bit           last_q[$];
    int n_perm, n_done, n_unstable, n_gap_bad, n_blocks;
    bit timed_out, busy_after_start, first_lat_ok;

    // Reference: a fresh random state per block; its first rate/8 bytes extend the XOF stream.
    task automatic give_block(input int rb);
        logic [1599:0] blk;
        for (int w = 0; w < 50; w++) blk[32*w +: 32] = $urandom;
        state_i = blk;
        for (int k = 0; k < rb; k++) exp_q.push_back(blk[8*k +: 8]);
        n_blocks++;
    endtask

    function automatic int byte_diffs(input int len);
        int d = 0;
        if (got_q.size() != len || exp_q.size() < len) return len + 1;
        for (int i = 0; i < len; i++) if (got_q[i] != exp_q[i]) d++;
        return d;
    endfunction

    task automatic run_op(input int rate, input int len, input int rdy_pct, input bit extra_start);
        int rb, wait_cnt, post;
        bit need_blk, prev_stall, prev_perm, prev_hs, first_pend, first_blk, done_seen;
        logic [255:0] s_data;
        logic [31:0]  s_keep;
        logic         s_last;
        rb = rate / 8;
        exp_q.delete(); got_q.delete(); keep_q.delete(); last_q.delete();
        n_perm = 0; n_done = 0; n_unstable = 0; n_gap_bad = 0; n_blocks = 0;
        timed_out = 0; first_lat_ok = 0; post = 0;
        prev_stall = 0; prev_perm = 0; prev_hs = 0; first_pend = 0; done_seen = 0;
        s_data = '0; s_keep = '0; s_last = 0;
        @(negedge clk);
        rate_i = 11'(rate); out_len_i = 16'(len); start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        busy_after_start = busy_o;
        need_blk = (len > 0); first_blk = 1; wait_cnt = $urandom_range(0, 3);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            state_valid_i = 1'b0;
            start_i = 1'b0;
            if (done_o) begin n_done++; done_seen = 1; end
            if (first_pend) begin first_lat_ok = m_axis_tvalid; first_pend = 0; end
            if (prev_stall && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== s_data ||
                               m_axis_tkeep !== s_keep || m_axis_tlast !== s_last)) n_unstable++;
            if (perm_req_o && !prev_perm) begin
                n_perm++;
                if (!prev_hs) n_gap_bad++;
                need_blk = 1; wait_cnt = $urandom_range(0, 3);
            end
            prev_perm = perm_req_o;
            if (done_seen) begin post++; if (post > 4) break; end
            if (extra_start && cyc == 4 && busy_o) begin start_i = 1'b1; out_len_i = 16'd5; end
            m_axis_tready = ($urandom_range(0, 99) < rdy_pct);
            prev_hs = m_axis_tvalid && m_axis_tready;
            if (prev_hs) begin
                keep_q.push_back(m_axis_tkeep);
                last_q.push_back(m_axis_tlast);
                for (int j = 0; j < 32; j++) if (m_axis_tkeep[j]) got_q.push_back(m_axis_tdata[8*j +: 8]);
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            s_data = m_axis_tdata; s_keep = m_axis_tkeep; s_last = m_axis_tlast;
            if (need_blk) begin
                if (wait_cnt == 0) begin
                    give_block(rb);
                    state_valid_i = 1'b1;
                    need_blk = 0;
                    if (first_blk) begin first_pend = 1; first_blk = 0; end
                end else wait_cnt--;
            end
            @(negedge clk);
        end
        state_valid_i = 1'b0; start_i = 1'b0; m_axis_tready = 1'b0;
        timed_out = !done_seen;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_cmp++; if (perm_req_o !== 1'b0) begin n_err++; $display("FAIL rst_perm_req: got %b want 0", perm_req_o); end
        n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_tvalid: got %b want 0", m_axis_tvalid); end
        n_cmp++; if (m_axis_tlast !== 1'b0) begin n_err++; $display("FAIL rst_tlast: got %b want 0", m_axis_tlast); end
        n_cmp++; if (m_axis_tdata !== 256'd0) begin n_err++; $display("FAIL rst_tdata: got %h want 0", m_axis_tdata); end
        n_cmp++; if (m_axis_tkeep !== 32'd0) begin n_err++; $display("FAIL rst_tkeep: got %h want 0", m_axis_tkeep); end
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy_o); end
        n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", done_o); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (m_axis_tvalid !== 1'b0 || busy_o !== 1'b0) begin n_err++; $display("FAIL post_rst_idle: got tvalid %b busy %b want 0 0", m_axis_tvalid, busy_o); end
    endtask

    task automatic test_sha3_256;
        run_op(1088, 32, 100, 0);
        n_cmp++; if (timed_out) begin n_err++; $display("FAIL sha256_timeout: got no done want done"); end
        n_cmp++; if (busy_after_start !== 1'b1) begin n_err++; $display("FAIL sha256_busy_n1: got %b want 1", busy_after_start); end
        n_cmp++; if (first_lat_ok !== 1'b1) begin n_err++; $display("FAIL sha256_first_tvalid: got %b want 1", first_lat_ok); end
        n_cmp++; if (keep_q.size() != 1) begin n_err++; $display("FAIL sha256_beats: got %0d want 1", keep_q.size()); end
        else begin
            n_cmp++; if (keep_q[0] !== 32'hFFFFFFFF) begin n_err++; $display("FAIL sha256_tkeep: got %h want ffffffff", keep_q[0]); end
            n_cmp++; if (last_q[0] !== 1'b1) begin n_err++; $display("FAIL sha256_tlast: got %b want 1", last_q[0]); end
        end
        n_cmp++; if (n_perm != 0) begin n_err++; $display("FAIL sha256_perm: got %0d want 0", n_perm); end
        n_cmp++; if (n_done != 1) begin n_err++; $display("FAIL sha256_done: got %0d want 1", n_done); end
        n_cmp++; if (byte_diffs(32) != 0) begin n_err++; $display("FAIL sha256_bytes: got %0d diffs want 0", byte_diffs(32)); end
    endtask

    task automatic test_sha3_512;
        run_op(576, 64, 100, 0);
        n_cmp++; if (keep_q.size() != 2) begin n_err++; $display("FAIL sha512_beats: got %0d want 2", keep_q.size()); end
        else begin
            n_cmp++; if (last_q[0] !== 1'b0 || last_q[1] !== 1'b1) begin n_err++; $display("FAIL sha512_tlast: got %b%b want 01", last_q[0], last_q[1]); end
            n_cmp++; if (keep_q[1] !== 32'hFFFFFFFF) begin n_err++; $display("FAIL sha512_tkeep: got %h want ffffffff", keep_q[1]); end
        end
        n_cmp++; if (n_perm != 0) begin n_err++; $display("FAIL sha512_perm: got %0d want 0", n_perm); end
        n_cmp++; if (byte_diffs(64) != 0) begin n_err++; $display("FAIL sha512_bytes: got %0d diffs want 0", byte_diffs(64)); end
    endtask

    task automatic test_shake128;
        run_op(1344, 200, 100, 0);
        n_cmp++; if (keep_q.size() != 7) begin n_err++; $display("FAIL shake128_beats: got %0d want 7", keep_q.size()); end
        else begin
            n_cmp++; if (keep_q[5] !== 32'hFFFFFFFF) begin n_err++; $display("FAIL shake128_beat6_keep: got %h want ffffffff", keep_q[5]); end
            n_cmp++; if (keep_q[6] !== 32'h000000FF || last_q[6] !== 1'b1) begin n_err++; $display("FAIL shake128_last_beat: got keep %h last %b want ff 1", keep_q[6], last_q[6]); end
        end
        n_cmp++; if (n_perm != 1 || n_blocks != 2) begin n_err++; $display("FAIL shake128_perm: got %0d perms %0d blocks want 1 2", n_perm, n_blocks); end
        n_cmp++; if (n_gap_bad != 0) begin n_err++; $display("FAIL shake128_perm_timing: got %0d late want 0", n_gap_bad); end
        n_cmp++; if (byte_diffs(200) != 0) begin n_err++; $display("FAIL shake128_bytes: got %0d diffs want 0", byte_diffs(200)); end
`ifdef KECCAK_SQUEEZE_STATS_EN
        n_cmp++; if (perm_cnt_o !== 16'd1) begin n_err++; $display("FAIL shake128_perm_cnt: got %0d want 1", perm_cnt_o); end
`endif
    endtask

    task automatic test_backpressure;
        int rates[5] = '{576, 832, 1088, 1152, 1344};
        int r, len, rb, nl;
        run_op(1088, 300, 50, 0);
        n_cmp++; if (n_unstable != 0) begin n_err++; $display("FAIL bp_stable: got %0d unstable want 0", n_unstable); end
        n_cmp++; if (keep_q.size() != 10) begin n_err++; $display("FAIL bp_beats: got %0d want 10", keep_q.size()); end
        else begin
            n_cmp++; if (keep_q[9] !== 32'h00000FFF) begin n_err++; $display("FAIL bp_last_keep: got %h want fff", keep_q[9]); end
            nl = 0; foreach (last_q[i]) if (last_q[i] != (i == 9)) nl++;
            n_cmp++; if (nl != 0) begin n_err++; $display("FAIL bp_tlast_pos: got %0d bad want 0", nl); end
        end
        n_cmp++; if (n_perm != 2) begin n_err++; $display("FAIL bp_perm: got %0d want 2", n_perm); end
        n_cmp++; if (byte_diffs(300) != 0) begin n_err++; $display("FAIL bp_bytes: got %0d diffs want 0", byte_diffs(300)); end
        n_cmp++; if (n_done != 1) begin n_err++; $display("FAIL bp_done: got %0d want 1", n_done); end
        for (int it = 0; it < 5; it++) begin
            r = rates[$urandom_range(0, 4)]; len = $urandom_range(1, 400); rb = r / 8;
            run_op(r, len, $urandom_range(20, 100), 0);
            n_cmp++; if (byte_diffs(len) != 0) begin n_err++; $display("FAIL rnd_bytes rate %0d len %0d: got %0d diffs want 0", r, len, byte_diffs(len)); end
            n_cmp++; if (keep_q.size() != (len + 31) / 32) begin n_err++; $display("FAIL rnd_beats rate %0d len %0d: got %0d want %0d", r, len, keep_q.size(), (len + 31) / 32); end
            n_cmp++; if (n_perm != (len + rb - 1) / rb - 1) begin n_err++; $display("FAIL rnd_perm rate %0d len %0d: got %0d want %0d", r, len, n_perm, (len + rb - 1) / rb - 1); end
            n_cmp++; if (n_unstable != 0 || n_done != 1) begin n_err++; $display("FAIL rnd_flow: got unstable %0d done %0d want 0 1", n_unstable, n_done); end
        end
    endtask

    task automatic test_zero_len;
        @(negedge clk);
        rate_i = 11'd1088; out_len_i = 16'd0; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        n_cmp++; if (done_o !== 1'b1) begin n_err++; $display("FAIL zero_done: got %b want 1", done_o); end
        n_cmp++; if (m_axis_tvalid !== 1'b0 || busy_o !== 1'b0) begin n_err++; $display("FAIL zero_idle: got tvalid %b busy %b want 0 0", m_axis_tvalid, busy_o); end
        @(negedge clk);
        n_cmp++; if (done_o !== 1'b0 || m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL zero_after: got done %b tvalid %b want 0 0", done_o, m_axis_tvalid); end
    endtask

    task automatic test_start_while_busy;
        run_op(1088, 64, 30, 1);
        n_cmp++; if (keep_q.size() != 2) begin n_err++; $display("FAIL busy_start_beats: got %0d want 2", keep_q.size()); end
        n_cmp++; if (byte_diffs(64) != 0) begin n_err++; $display("FAIL busy_start_bytes: got %0d diffs want 0", byte_diffs(64)); end
        n_cmp++; if (n_done != 1) begin n_err++; $display("FAIL busy_start_done: got %0d want 1", n_done); end
    endtask

    task automatic test_reset_mid_perm;
        exp_q.delete();
        @(negedge clk);
        rate_i = 11'd1344; out_len_i = 16'd200; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        give_block(168);
        state_valid_i = 1'b1; m_axis_tready = 1'b1;
        @(negedge clk);
        state_valid_i = 1'b0;
        for (int i = 0; i < 100 && !perm_req_o; i++) @(negedge clk);
        n_cmp++; if (perm_req_o !== 1'b1) begin n_err++; $display("FAIL mid_perm_reached: got %b want 1", perm_req_o); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (perm_req_o !== 1'b0 || m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0)
            begin n_err++; $display("FAIL mid_rst_ctrl: got perm %b tvalid %b tlast %b want 0 0 0", perm_req_o, m_axis_tvalid, m_axis_tlast); end
        n_cmp++; if (m_axis_tdata !== 256'd0 || m_axis_tkeep !== 32'd0)
            begin n_err++; $display("FAIL mid_rst_data: got tdata %h tkeep %h want 0 0", m_axis_tdata, m_axis_tkeep); end
        n_cmp++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin n_err++; $display("FAIL mid_rst_status: got busy %b done %b want 0 0", busy_o, done_o); end
`ifdef KECCAK_SQUEEZE_STATS_EN
        n_cmp++; if (perm_cnt_o !== 16'd0) begin n_err++; $display("FAIL mid_rst_perm_cnt: got %0d want 0", perm_cnt_o); end
`endif
        m_axis_tready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1088, 32, 100, 0);
        n_cmp++; if (keep_q.size() != 1 || n_done != 1) begin n_err++; $display("FAIL post_rst_op: got beats %0d done %0d want 1 1", keep_q.size(), n_done); end
        n_cmp++; if (byte_diffs(32) != 0) begin n_err++; $display("FAIL post_rst_bytes: got %0d diffs want 0", byte_diffs(32)); end
    endtask

    initial begin
        test_reset();
        test_sha3_256();
        test_sha3_512();
        test_shake128();
        test_backpressure();
        test_zero_len();
        test_start_while_busy();
        test_reset_mid_perm();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
